// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : Default 640x480@60 raster constants, derived sync windows and the
//            shared 10-bit coordinate type used by the pixel generators.
// Revision : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef logic [9:0] coord_t;

    // Half-open window test lo <= v < hi
    function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// Module   : clk_en_div
// Brief    : Divides clk by CLK_DIV into a registered one-clk enable pulse.
// Revision : 1.0 - initial release
// ============================================================================
module clk_en_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int c_CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_div_cnt;
    logic [c_CNT_W-1:0] w_div_cnt_next;
    logic               r_p_tick;

    always_comb begin
        w_div_cnt_next = r_div_cnt + c_CNT_W'(1);
        if (r_div_cnt == c_CNT_MAX) begin
            w_div_cnt_next = '0;
        end
    end

    // Tick is registered off the next count so it is high while the count sits at its max.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_p_tick  <= 1'b0;
        end else begin
            r_div_cnt <= w_div_cnt_next;
            r_p_tick  <= (w_div_cnt_next == c_CNT_MAX);
        end
    end

    assign p_tick = r_p_tick;

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing (x/y, video_on, hsync/vsync, frame_start).
//            Define VGA_SYNC_PIPE_EN to delay hsync/vsync/video_on by one pixel.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int     c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t c_H_MAX    = coord_t'(c_H_TOTAL - 1);
    localparam coord_t c_V_MAX    = coord_t'(c_V_TOTAL - 1);
    localparam coord_t c_H_ACT    = coord_t'(H_ACTIVE);
    localparam coord_t c_V_ACT    = coord_t'(V_ACTIVE);
    localparam coord_t c_HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t c_HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t c_VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t c_VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic   w_tick;
    coord_t r_x;
    coord_t r_y;
    coord_t w_x_next;
    coord_t w_y_next;
    logic   w_x_wrap;
    logic   w_y_wrap;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame_start;
    logic   w_video_on;

    clk_en_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (w_tick)
    );

    always_comb begin
        w_x_wrap = (r_x == c_H_MAX);
        w_y_wrap = (r_y == c_V_MAX);
        w_x_next = r_x;
        w_y_next = r_y;
        if (w_tick) begin
            if (w_x_wrap) begin
                w_x_next = '0;
                w_y_next = w_y_wrap ? '0 : r_y + coord_t'(1);
            end else begin
                w_x_next = r_x + coord_t'(1);
            end
        end
    end

    // Syncs decode the next count so they switch on the same edge as x/y.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_frame_start <= 1'b0;
        end else begin
            r_x           <= w_x_next;
            r_y           <= w_y_next;
            r_hsync       <= in_span(w_x_next, c_HS_START, c_HS_END) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= in_span(w_y_next, c_VS_START, c_VS_END) ? SYNC_POL : ~SYNC_POL;
            r_frame_start <= w_tick & w_x_wrap & w_y_wrap;
        end
    end

    assign w_video_on = (r_x < c_H_ACT) && (r_y < c_V_ACT);

`ifdef VGA_SYNC_PIPE_EN
    logic r_hsync_d;
    logic r_vsync_d;
    logic r_video_on_d;

    // One-pixel lag so the syncs line up with a registered rgb downstream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hsync_d    <= ~SYNC_POL;
            r_vsync_d    <= ~SYNC_POL;
            r_video_on_d <= 1'b0;
        end else if (w_tick) begin
            r_hsync_d    <= r_hsync;
            r_vsync_d    <= r_vsync;
            r_video_on_d <= w_video_on;
        end
    end

    assign hsync    = r_hsync_d;
    assign vsync    = r_vsync_d;
    assign video_on = r_video_on_d;
`else
    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = w_video_on;
`endif

    assign p_tick      = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Randomised-reset bench for vga_timing_gen against an arithmetic
//            raster model (default geometry plus two reduced geometries).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    typedef struct packed {
        logic       fs;
        logic       pt;
        logic       von;
        logic       hs;
        logic       vs;
        logic [9:0] y;
        logic [9:0] x;
    } obs_t;

    typedef struct {
        int cd;
        int ha, hfp, hsw, hbp;
        int va, vfp, vsw, vbp;
        bit pol;
    } cfg_t;

    logic clk;
    logic reset;
    int   k;
    int   checks;
    int   errors;

    cfg_t c0, c1, c2;

    logic       pt0, von0, hs0, vs0, fs0;
    logic [9:0] x0, y0;
    logic       pt1, von1, hs1, vs1, fs1;
    logic [9:0] x1, y1;
    logic       pt2, von2, hs2, vs2, fs2;
    logic [9:0] x2, y2;

    vga_timing_gen u_dut0 (
        .clk(clk), .reset(reset), .p_tick(pt0), .x(x0), .y(y0),
        .video_on(von0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(6), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
    ) u_dut1 (
        .clk(clk), .reset(reset), .p_tick(pt1), .x(x1), .y(y1),
        .video_on(von1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0)
    ) u_dut2 (
        .clk(clk), .reset(reset), .p_tick(pt2), .x(x2), .y(y2),
        .video_on(von2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pixel advances completed k clks after reset release.
    function automatic int adv(int cd, int kk);
        if (kk <= 0) return 0;
        return kk / cd - ((cd == 1) ? 1 : 0);
    endfunction

    function automatic obs_t model(cfg_t c, int kk);
        obs_t o;
        int   ht, vt, a, p, px, py;
        ht   = c.ha + c.hfp + c.hsw + c.hbp;
        vt   = c.va + c.vfp + c.vsw + c.vbp;
        a    = adv(c.cd, kk);
        o.x  = 10'(a % ht);
        o.y  = 10'((a / ht) % vt);
        o.pt = (kk >= 1) && ((kk % c.cd) == c.cd - 1);
        o.fs = (kk >= 1) && (a != adv(c.cd, kk - 1)) && ((a % (ht * vt)) == 0);
`ifdef VGA_SYNC_PIPE_EN
        p = a - 1;
`else
        p = a;
`endif
        if (p < 0) begin
            o.von = 1'b0;
            o.hs  = ~c.pol;
            o.vs  = ~c.pol;
        end else begin
            px    = p % ht;
            py    = (p / ht) % vt;
            o.von = (px < c.ha) && (py < c.va);
            o.hs  = (px >= c.ha + c.hfp && px < c.ha + c.hfp + c.hsw) ? c.pol : ~c.pol;
            o.vs  = (py >= c.va + c.vfp && py < c.va + c.vfp + c.vsw) ? c.pol : ~c.pol;
        end
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %0d expected %0d", tag, k, got, exp);
        end
    endtask

    task automatic check_inst(input string n, input obs_t got, input obs_t exp);
        check({n, ".x"}, 32'(got.x), 32'(exp.x));
        check({n, ".y"}, 32'(got.y), 32'(exp.y));
        check({n, ".p_tick"}, 32'(got.pt), 32'(exp.pt));
        check({n, ".video_on"}, 32'(got.von), 32'(exp.von));
        check({n, ".hsync"}, 32'(got.hs), 32'(exp.hs));
        check({n, ".vsync"}, 32'(got.vs), 32'(exp.vs));
        check({n, ".frame_start"}, 32'(got.fs), 32'(exp.fs));
    endtask

    task automatic check_all();
        check_inst("d0", {fs0, pt0, von0, hs0, vs0, y0, x0}, model(c0, k));
        check_inst("d1", {fs1, pt1, von1, hs1, vs1, y1, x1}, model(c1, k));
        check_inst("d2", {fs2, pt2, von2, hs2, vs2, y2, x2}, model(c2, k));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!reset) k++;
        check_all();
    endtask

    // Entered 1 time unit after a rising edge; reset lands mid-cycle.
    task automatic do_reset(input int hold);
        #2 reset = 1'b1;
        #1 k = 0;
        check_all();
        for (int i = 0; i < hold; i++) step();
        @(negedge clk) reset = 1'b0;
    endtask

    initial begin
        int len;
        int guard;
        c0 = '{cd: 4, ha: 640, hfp: 16, hsw: 96, hbp: 48,
               va: 480, vfp: 10, vsw: 2, vbp: 33, pol: 1'b0};
        c1 = '{cd: 3, ha: 6, hfp: 2, hsw: 3, hbp: 2,
               va: 4, vfp: 1, vsw: 2, vbp: 2, pol: 1'b1};
        c2 = '{cd: 1, ha: 5, hfp: 1, hsw: 2, hbp: 1,
               va: 3, vfp: 1, vsw: 1, vbp: 2, pol: 1'b0};
        checks = 0;
        errors = 0;
        k      = 0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset = 1'b0;

        // A full line of the default geometry and many small frames.
        for (int i = 0; i < 3300 && errors <= 40; i++) step();

        // Reset in the middle of a default line, at x=300.
        guard = 0;
        while (adv(4, k) != 2 * 800 + 300 && guard < 20000 && errors <= 40) begin
            step();
            guard++;
        end
        check("reach_x300", 32'(x0), 32'd300);
        do_reset(1);

        for (int s = 0; s < 12 && errors <= 40; s++) begin
            len = $urandom_range(400, 4500);
            for (int i = 0; i < len && errors <= 40; i++) step();
            do_reset($urandom_range(0, 3));
        end
        for (int i = 0; i < 1200 && errors <= 40; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
